// File: rtl/prog_timer_if.sv
// Control/status bundle for prog_timer.
// master drives the controls (enable, load, load_value, prescale, mode,
// start, stop); slave returns the status (count, running, done, expired).
// With PROG_TIMER_IRQ_EN: irq_clear (master -> slave), irq (slave -> master).
interface prog_timer_if #(
    parameter int WIDTH    = 8,
    parameter int PS_WIDTH = 4
);
    logic                enable;
    logic                load;
    logic [WIDTH-1:0]    load_value;
    logic [PS_WIDTH-1:0] prescale;
    logic                mode;
    logic                start;
    logic                stop;
    logic [WIDTH-1:0]    count;
    logic                running;
    logic                done;
    logic                expired;
`ifdef PROG_TIMER_IRQ_EN
    logic                irq_clear;
    logic                irq;
`endif

    modport master (
        output enable, load, load_value, prescale, mode, start, stop,
`ifdef PROG_TIMER_IRQ_EN
        output irq_clear,
        input  irq,
`endif
        input  count, running, done, expired
    );

    modport slave (
        input  enable, load, load_value, prescale, mode, start, stop,
`ifdef PROG_TIMER_IRQ_EN
        input  irq_clear,
        output irq,
`endif
        output count, running, done, expired
    );
endinterface

// File: rtl/prog_timer.sv
// Programmable timer: period register, prescaler, start/stop, one-shot or
// periodic mode, one-cycle done pulse at each terminal count.
// Ports: clk, reset (sync, active-high), bus (prog_timer_if.slave).
// Optional macro PROG_TIMER_IRQ_EN adds a sticky irq with irq_clear.
module prog_timer #(
    parameter int WIDTH    = 8,
    parameter int PS_WIDTH = 4
) (
    input logic          clk,
    input logic          reset,
    prog_timer_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, RUN, EXPIRED} state_t;

    state_t              state, state_n;
    logic [WIDTH-1:0]    count_q, count_n;
    logic [WIDTH-1:0]    period_q, period_n;
    logic [PS_WIDTH-1:0] psc_q, psc_n;
    logic                mode_q, mode_n;
    logic                done_q, done_n;
    logic                running_q, expired_q;
    logic                tick;

    always_comb begin
        tick = (state == RUN) && bus.enable && (psc_q == bus.prescale);
    end

    always_comb begin
        state_n  = state;
        count_n  = count_q;
        psc_n    = psc_q;
        mode_n   = mode_q;
        done_n   = 1'b0;
        // load is independent of the FSM; with start it sets the new run's period
        period_n = bus.load ? bus.load_value : period_q;
        if (bus.stop) begin
            if (state == RUN)
                state_n = IDLE;
        end else if (bus.start) begin
            state_n = RUN;
            count_n = '0;
            psc_n   = '0;
            mode_n  = bus.mode;
        end else if (state == RUN && bus.enable) begin
            if (tick) begin
                psc_n = '0;
                if (count_q == period_q) begin
                    count_n = '0;
                    done_n  = 1'b1;
                    if (mode_q)
                        state_n = EXPIRED;
                end else begin
                    // a shrunk period below count wraps through all ones
                    count_n = count_q + 1'b1;
                end
            end else begin
                psc_n = psc_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            count_q   <= '0;
            period_q  <= '1;
            psc_q     <= '0;
            mode_q    <= 1'b0;
            done_q    <= 1'b0;
            running_q <= 1'b0;
            expired_q <= 1'b0;
        end else begin
            state     <= state_n;
            count_q   <= count_n;
            period_q  <= period_n;
            psc_q     <= psc_n;
            mode_q    <= mode_n;
            done_q    <= done_n;
            running_q <= (state_n == RUN);
            expired_q <= (state_n == EXPIRED);
        end
    end

    assign bus.count   = count_q;
    assign bus.running = running_q;
    assign bus.done    = done_q;
    assign bus.expired = expired_q;

`ifdef PROG_TIMER_IRQ_EN
    logic irq_q;

    // set wins over a simultaneous clear
    always_ff @(posedge clk) begin
        if (reset)
            irq_q <= 1'b0;
        else if (done_n)
            irq_q <= 1'b1;
        else if (bus.irq_clear)
            irq_q <= 1'b0;
    end

    assign bus.irq = irq_q;
`endif
endmodule

// File: tb/tb_prog_timer.sv
// Directed self-checking bench for prog_timer.
// Steps are linear in one initial block; expectations are hand-computed.
module tb_prog_timer;
    logic clk;
    logic reset;
    int   n_vec;
    int   n_err;
    logic seen;

    prog_timer_if #(.WIDTH(8), .PS_WIDTH(4)) bus ();

    prog_timer #(.WIDTH(8), .PS_WIDTH(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic idle_ctl();
        bus.load  = 1'b0;
        bus.start = 1'b0;
        bus.stop  = 1'b0;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        reset = 1'b1;
        bus.enable     = 1'b1;
        bus.load       = 1'b0;
        bus.load_value = '0;
        bus.prescale   = '0;
        bus.mode       = 1'b0;
        bus.start      = 1'b0;
        bus.stop       = 1'b0;
`ifdef PROG_TIMER_IRQ_EN
        bus.irq_clear  = 1'b0;
`endif
        step(2);
        chk("rst_count", bus.count, 0);
        chk("rst_running", bus.running, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_expired", bus.expired, 0);
        reset = 1'b0;

        // periodic, period 3, prescale 0
        bus.load = 1'b1; bus.load_value = 8'd3; bus.start = 1'b1;
        step(1);
        idle_ctl();
        chk("per_start_count", bus.count, 0);
        chk("per_start_run", bus.running, 1);
        for (int p = 0; p < 3; p++) begin
            for (int i = 1; i <= 4; i++) begin
                step(1);
                chk("per_count", bus.count, i % 4);
                chk("per_done", bus.done, (i == 4) ? 1 : 0);
                chk("per_run", bus.running, 1);
            end
        end

        // one-shot, period 2, prescale 2
        bus.load = 1'b1; bus.load_value = 8'd2; bus.start = 1'b1;
        bus.prescale = 4'd2; bus.mode = 1'b1;
        step(1);
        idle_ctl();
        bus.mode = 1'b0;
        for (int i = 1; i <= 9; i++) begin
            step(1);
            chk("os_count", bus.count, (i == 9) ? 0 : i / 3);
            chk("os_done", bus.done, (i == 9) ? 1 : 0);
        end
        chk("os_expired", bus.expired, 1);
        chk("os_running", bus.running, 0);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step(1);
            if (bus.done) seen = 1'b1;
        end
        chk("os_no_more_done", seen, 0);
        chk("os_count_hold", bus.count, 0);
        chk("os_expired_hold", bus.expired, 1);

        // enable gating, period 5, prescale 0
        bus.prescale = 4'd0;
        bus.load = 1'b1; bus.load_value = 8'd5; bus.start = 1'b1;
        step(1);
        idle_ctl();
        chk("en_start_expired", bus.expired, 0);
        chk("en_start_run", bus.running, 1);
        step(2);
        chk("en_count2", bus.count, 2);
        bus.enable = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step(1);
            chk("en_hold", bus.count, 2);
            chk("en_hold_done", bus.done, 0);
        end
        bus.enable = 1'b1;
        step(1); chk("en_c3", bus.count, 3);
        step(1); chk("en_c4", bus.count, 4);
        step(1); chk("en_c5", bus.count, 5);
        chk("en_c5_done", bus.done, 0);
        step(1);
        chk("en_term_count", bus.count, 0);
        chk("en_term_done", bus.done, 1);

        // stop + start together in RUN
        step(2);
        chk("ss_pre", bus.count, 2);
        bus.stop = 1'b1; bus.start = 1'b1;
        step(1);
        idle_ctl();
        chk("ss_running", bus.running, 0);
        chk("ss_count", bus.count, 2);
        step(2);
        chk("ss_idle_count", bus.count, 2);
        chk("ss_idle_done", bus.done, 0);

        // load 7 + start together
        bus.load = 1'b1; bus.load_value = 8'd7; bus.start = 1'b1;
        step(1);
        idle_ctl();
        chk("ls_count", bus.count, 0);
        for (int i = 1; i <= 8; i++) begin
            step(1);
            chk("ls_count", bus.count, i % 8);
            chk("ls_done", bus.done, (i == 8) ? 1 : 0);
        end

        // restart at count 4
        step(4);
        chk("rs_pre", bus.count, 4);
        bus.start = 1'b1;
        step(1);
        idle_ctl();
        chk("rs_count", bus.count, 0);
        chk("rs_done", bus.done, 0);
        chk("rs_run", bus.running, 1);
        step(1);
        chk("rs_next", bus.count, 1);

        // period shrink below count
        bus.load = 1'b1; bus.load_value = 8'd20; bus.start = 1'b1;
        step(1);
        idle_ctl();
        step(10);
        chk("sh_count10", bus.count, 10);
        bus.load = 1'b1; bus.load_value = 8'd5;
        step(1);
        idle_ctl();
        chk("sh_count11", bus.count, 11);
        seen = 1'b0;
        for (int i = 0; i < 244; i++) begin
            step(1);
            if (bus.done) seen = 1'b1;
        end
        chk("sh_no_done", seen, 0);
        chk("sh_count255", bus.count, 255);
        step(1);
        chk("sh_wrap", bus.count, 0);
        chk("sh_wrap_done", bus.done, 0);
        step(5);
        chk("sh_count5", bus.count, 5);
        chk("sh_c5_done", bus.done, 0);
        step(1);
        chk("sh_term", bus.count, 0);
        chk("sh_term_done", bus.done, 1);

        // reset mid-run restores period 255
        step(3);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        chk("mr_count", bus.count, 0);
        chk("mr_running", bus.running, 0);
        chk("mr_done", bus.done, 0);
        chk("mr_expired", bus.expired, 0);
        bus.start = 1'b1;
        step(1);
        idle_ctl();
        step(255);
        chk("mr_count255", bus.count, 255);
        chk("mr_done255", bus.done, 0);
        step(1);
        chk("mr_term", bus.count, 0);
        chk("mr_term_done", bus.done, 1);

`ifdef PROG_TIMER_IRQ_EN
        chk("irq_set", bus.irq, 1);
        step(3);
        chk("irq_hold", bus.irq, 1);
        bus.irq_clear = 1'b1;
        step(1);
        bus.irq_clear = 1'b0;
        chk("irq_clr", bus.irq, 0);
        bus.load = 1'b1; bus.load_value = 8'd0; bus.start = 1'b1;
        step(1);
        idle_ctl();
        bus.irq_clear = 1'b1;
        step(1);
        chk("irq_coinc_done", bus.done, 1);
        chk("irq_coinc", bus.irq, 1);
        bus.stop = 1'b1;
        step(1);
        idle_ctl();
        bus.irq_clear = 1'b0;
        chk("irq_stop_done", bus.done, 0);
        chk("irq_stop_clr", bus.irq, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/prog_timer.md
Name: prog_timer

Overview:
- Parametrised programmable timer; next generation of the free-running terminal-count timer.
- Adds a run-time period register, a prescaler, start/stop control, and one-shot or periodic mode.
- Produces a one-cycle `done` pulse at each terminal count.
- Used by control FSMs and peripherals for delays, timeouts and periodic ticks.

Parameters:
- WIDTH, 8, counter and period width in bits.
- PS_WIDTH, 4, prescaler width in bits; divide ratio is prescale+1.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- enable  input  1  count enable; 0 freezes prescaler and counter.
- load  input  1  write load_value into period register.
- load_value  input  WIDTH  new terminal value.
- prescale  input  PS_WIDTH  prescaler divide-minus-one; sampled every cycle.
- mode  input  1  0 = periodic, 1 = one-shot; sampled on start.
- start  input  1  start or restart the timer.
- stop  input  1  halt the timer.
- count  output  WIDTH  current count value.
- running  output  1  high in RUN state.
- done  output  1  one-cycle pulse at terminal count.
- expired  output  1  one-shot completed; sticky until next start or reset.

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high (reset). All outputs are registered.
- Reset values:
  - State IDLE.
  - count=0, running=0, done=0, expired=0.
  - Period register = all ones (2^WIDTH-1).
  - Prescaler counter = 0; latched mode = periodic.
- States:
  - IDLE: not counting, count held.
  - RUN: counting.
  - EXPIRED: one-shot finished, count=0.
- Control priority per edge: reset > stop > start. `load` is independent and is applied in any state.
- load and start on the same edge: the new load_value is the period for the new run.
- start in any state:
  - Next state RUN; count←0; prescaler←0; expired←0; latch mode.
  - In RUN this is a restart.
- stop:
  - RUN → IDLE, count held.
  - stop in IDLE or EXPIRED has no effect.
  - stop and start on the same edge: stop wins.
- Tick:
  - Generated in RUN with enable=1 when prescaler==prescale; prescaler then returns to 0.
  - Otherwise the prescaler increments.
  - prescale=0 gives a tick every enabled cycle.
  - If prescale is lowered below the current prescaler value, the prescaler wraps naturally at 2^PS_WIDTH-1 and then continues normally.
- On tick with count != period: count←count+1.
- On tick with count == period:
  - count←0; done=1 for exactly the following cycle.
  - Periodic mode: stay in RUN.
  - One-shot mode: →EXPIRED, expired←1.
- Terminal spacing: period P gives P+1 ticks between done pulses. P=0 gives done on every tick.
- Period changes during RUN:
  - A load takes effect on the next compare.
  - If the new period is below the current count, the counter runs to 2^WIDTH-1, wraps to 0 without done, then compares normally.
- enable=0 freezes the prescaler and count; FSM transitions (start, stop) still occur.
- done never asserts outside a terminal tick; start, stop and reset clear any pending done on the next edge.
- Outputs: running = (state==RUN); expired is high only in EXPIRED.

Optional Feature:
- Macro: PROG_TIMER_IRQ_EN.
- When defined:
  - Adds input irq_clear (1 bit) and output irq (1 bit).
  - irq is set on every edge where done is set, and cleared by irq_clear.
  - Set wins over a simultaneous clear; reset clears irq.
- When undefined: neither port exists and no irq logic is built.

Test Plan:
- Periodic, WIDTH=8, load 3, prescale=0, mode=0, start at edge k:
  - count 0,1,2,3,0,…
  - done high after edges k+4, k+8, k+12; running stays 1.
- One-shot, period 2, prescale=2:
  - Ticks every 3 cycles; done once after edge k+9.
  - State EXPIRED, expired=1, count=0; no further done over the next 20 cycles.
- enable gating, period 5: deassert enable for 4 cycles mid-count at count=2 → count holds at 2 and prescaler holds; done is delayed by exactly 4 cycles.
- Control collisions:
  - stop+start on the same edge in RUN → IDLE, count held.
  - load 7 + start on the same edge → next done after 8 ticks.
  - Restart at count=4 → count 0, no done.
- Period shrink: count=10, load 5 → counter runs to 255, wraps to 0 with no done, then done after count reaches 5.
- Reset and IRQ (with PROG_TIMER_IRQ_EN):
  - reset asserted mid-run → all outputs 0, period=255 next cycle.
  - irq sets on done and holds until irq_clear.
  - irq_clear coincident with done leaves irq=1.
